// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus of the two-requester register-file write arbiter.
// drop_count exists only when REGFILE_ARB_FILTER_EN is defined.
interface regfile_write_arbiter_if #(
  parameter int ID_W   = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req_a_valid;
  logic              req_a_ready;
  logic [ID_W-1:0]   req_a_id;
  logic [DATA_W-1:0] req_a_data;
  logic              req_b_valid;
  logic              req_b_ready;
  logic [ID_W-1:0]   req_b_id;
  logic [DATA_W-1:0] req_b_data;
  logic              hold;
  logic              write_enable;
  logic [ID_W-1:0]   reg_id_d;
  logic [DATA_W-1:0] reg_d_value;
  logic              busy;
  logic [CNT_W-1:0]  wr_count;
`ifdef REGFILE_ARB_FILTER_EN
  logic [CNT_W-1:0]  drop_count;
`endif

  modport master (
    output req_a_valid, req_a_id, req_a_data,
    output req_b_valid, req_b_id, req_b_data, hold,
    input  req_a_ready, req_b_ready, write_enable, reg_id_d, reg_d_value,
    input  busy, wr_count
`ifdef REGFILE_ARB_FILTER_EN
    , input drop_count
`endif
  );

  modport slave (
    input  req_a_valid, req_a_id, req_a_data,
    input  req_b_valid, req_b_id, req_b_data, hold,
    output req_a_ready, req_b_ready, write_enable, reg_id_d, reg_d_value,
    output busy, wr_count
`ifdef REGFILE_ARB_FILTER_EN
    , output drop_count
`endif
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between two
// one-entry writeback slots. REGFILE_ARB_FILTER_EN drops out-of-window ids.
module regfile_write_arbiter #(
  parameter int ID_W      = 5,
  parameter int DATA_W    = 32,
  parameter int REG_BASE  = 5,
  parameter int REG_COUNT = 3,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic rst,
  regfile_write_arbiter_if.slave bus
);
`ifdef REGFILE_ARB_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif
  localparam logic [ID_W:0] WIN_LO = (ID_W+1)'(REG_BASE);
  localparam logic [ID_W:0] WIN_HI = (ID_W+1)'(REG_BASE + REG_COUNT);

  typedef struct packed {
    logic              v;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } slot_t;

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_e;

  slot_t             slot_a, slot_b;
  last_e             last;
  logic              we_q;
  logic [ID_W-1:0]   id_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  wr_cnt_q;

  logic in_win_a, in_win_b, drop_a, drop_b, elig_a, elig_b;
  logic grant_a, grant_b, acc_a, acc_b;

  assign in_win_a = ({1'b0, slot_a.id} >= WIN_LO) && ({1'b0, slot_a.id} < WIN_HI);
  assign in_win_b = ({1'b0, slot_b.id} >= WIN_LO) && ({1'b0, slot_b.id} < WIN_HI);

  // Dropped entries bypass arbitration and are cleared regardless of hold.
  assign drop_a = FILTER && slot_a.v && !in_win_a;
  assign drop_b = FILTER && slot_b.v && !in_win_b;
  assign elig_a = slot_a.v && !drop_a;
  assign elig_b = slot_b.v && !drop_b;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!bus.hold) begin
      if (elig_a && elig_b) begin
        grant_a = (last == LAST_B);
        grant_b = (last == LAST_A);
      end else begin
        grant_a = elig_a;
        grant_b = elig_b;
      end
    end
  end

  // Ready also covers a slot draining this cycle, enabling drain-and-refill.
  assign bus.req_a_ready = !slot_a.v || grant_a;
  assign bus.req_b_ready = !slot_b.v || grant_b;
  assign acc_a = bus.req_a_valid && bus.req_a_ready;
  assign acc_b = bus.req_b_valid && bus.req_b_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_a   <= '0;
      slot_b   <= '0;
      last     <= LAST_B;
      we_q     <= 1'b0;
      id_q     <= '0;
      data_q   <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (acc_a)                  slot_a <= '{1'b1, bus.req_a_id, bus.req_a_data};
      else if (grant_a || drop_a) slot_a.v <= 1'b0;
      if (acc_b)                  slot_b <= '{1'b1, bus.req_b_id, bus.req_b_data};
      else if (grant_b || drop_b) slot_b.v <= 1'b0;

      if (grant_a || grant_b) begin
        we_q     <= 1'b1;
        id_q     <= grant_a ? slot_a.id   : slot_b.id;
        data_q   <= grant_a ? slot_a.data : slot_b.data;
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        last     <= grant_a ? LAST_A : LAST_B;
      end else begin
        we_q     <= 1'b0;
      end
    end
  end

`ifdef REGFILE_ARB_FILTER_EN
  logic [CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_q + CNT_W'(drop_a) + CNT_W'(drop_b);
  end

  assign bus.drop_count = drop_cnt_q;
`endif

  assign bus.write_enable = we_q;
  assign bus.reg_id_d     = id_q;
  assign bus.reg_d_value  = data_q;
  assign bus.wr_count     = wr_cnt_q;
  assign bus.busy         = slot_a.v || slot_b.v;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; expectations are hand-derived
// cycle by cycle. Honours REGFILE_ARB_FILTER_EN when defined.
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  regfile_write_arbiter_if #(.ID_W(5), .DATA_W(32), .CNT_W(16)) bus ();

  regfile_write_arbiter #(
    .ID_W(5), .DATA_W(32), .REG_BASE(5), .REG_COUNT(3), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.req_a_valid = 1'b0; bus.req_a_id = '0; bus.req_a_data = '0;
    bus.req_b_valid = 1'b0; bus.req_b_id = '0; bus.req_b_data = '0;
    bus.hold = 1'b0;
  endtask

  initial begin
    int ia, ib, tt;
    logic ea, eb;
    idle();
    rst = 1'b1;
    tick(); tick();

    // reset state
    chk("rst_we",    bus.write_enable, 0);
    chk("rst_id",    bus.reg_id_d, 0);
    chk("rst_data",  bus.reg_d_value, 0);
    chk("rst_cnt",   bus.wr_count, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_ra",    bus.req_a_ready, 1);
    chk("rst_rb",    bus.req_b_ready, 1);
`ifdef REGFILE_ARB_FILTER_EN
    chk("rst_drop",  bus.drop_count, 0);
`endif

    // single A write
    rst = 1'b0;
    bus.req_a_valid = 1'b1; bus.req_a_id = 5'd5; bus.req_a_data = 32'hDEADBEEF;
    tick();
    bus.req_a_valid = 1'b0;
    #1;
    chk("t1_busy", bus.busy, 1);
    chk("t1_we0",  bus.write_enable, 0);
    chk("t1_ra",   bus.req_a_ready, 1);
    tick();
    chk("t1_we1",  bus.write_enable, 1);
    chk("t1_id",   bus.reg_id_d, 5);
    chk("t1_data", bus.reg_d_value, 32'hDEADBEEF);
    chk("t1_cnt",  bus.wr_count, 1);
    chk("t1_busy0", bus.busy, 0);
    tick();
    chk("t1_we_off", bus.write_enable, 0);
    chk("t1_cnt2",   bus.wr_count, 1);
    chk("t1_id_keep", bus.reg_id_d, 5);

    // contention: both valid every cycle, grants alternate A,B starting with A
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ia = 0; ib = 0;
    bus.req_a_valid = 1'b1; bus.req_a_id = 5'd5;
    bus.req_b_valid = 1'b1; bus.req_b_id = 5'd6;
    for (int t = 0; t <= 8; t++) begin
      bus.req_a_data = 32'hA000_0000 + 32'(ia);
      bus.req_b_data = 32'hB000_0000 + 32'(ib);
      #1;
      ea = (t == 0) || (t % 2 == 1);
      eb = (t == 0) || (t % 2 == 0);
      chk("t2_ra", bus.req_a_ready, ea);
      chk("t2_rb", bus.req_b_ready, eb);
      if (t >= 2) begin
        tt = t - 1;
        chk("t2_we", bus.write_enable, 1);
        chk("t2_id", bus.reg_id_d, (tt % 2 == 1) ? 5 : 6);
        chk("t2_data", bus.reg_d_value, (tt % 2 == 1) ? 32'hA000_0000 + 32'((tt-1)/2)
                                                      : 32'hB000_0000 + 32'((tt-2)/2));
      end
      tick();
      if (ea) ia++;
      if (eb) ib++;
    end
    chk("t2_we8",   bus.write_enable, 1);
    chk("t2_data8", bus.reg_d_value, 32'hB000_0003);
    chk("t2_cnt8",  bus.wr_count, 8);
    bus.req_a_valid = 1'b0; bus.req_b_valid = 1'b0;
    tick();
    chk("t2_drain_a", bus.reg_d_value, 32'hA000_0004);
    chk("t2_cnt9",    bus.wr_count, 9);
    tick();
    chk("t2_drain_b", bus.reg_d_value, 32'hB000_0004);
    chk("t2_cnt10",   bus.wr_count, 10);
    chk("t2_busy0",   bus.busy, 0);

    // hold with both slots full
    bus.req_a_valid = 1'b1; bus.req_a_id = 5'd7; bus.req_a_data = 32'h111;
    bus.req_b_valid = 1'b1; bus.req_b_id = 5'd5; bus.req_b_data = 32'h222;
    bus.hold = 1'b1;
    #1;
    chk("t3_ra_empty", bus.req_a_ready, 1);
    chk("t3_rb_empty", bus.req_b_ready, 1);
    tick();
    bus.req_a_valid = 1'b0; bus.req_b_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_we",   bus.write_enable, 0);
      chk("t3_ra",   bus.req_a_ready, 0);
      chk("t3_rb",   bus.req_b_ready, 0);
      chk("t3_busy", bus.busy, 1);
      tick();
    end
    bus.hold = 1'b0;
    #1;
    chk("t3_rel_ra", bus.req_a_ready, 1);
    chk("t3_rel_rb", bus.req_b_ready, 0);
    tick();
    chk("t3_wa_we",   bus.write_enable, 1);
    chk("t3_wa_id",   bus.reg_id_d, 7);
    chk("t3_wa_data", bus.reg_d_value, 32'h111);
    tick();
    chk("t3_wb_we",   bus.write_enable, 1);
    chk("t3_wb_id",   bus.reg_id_d, 5);
    chk("t3_wb_data", bus.reg_d_value, 32'h222);
    chk("t3_busy0",   bus.busy, 0);
    chk("t3_cnt",     bus.wr_count, 12);
    tick();
    chk("t3_we_off",  bus.write_enable, 0);

    // reset while both slots full and a write is in flight
    bus.req_a_valid = 1'b1; bus.req_a_id = 5'd6; bus.req_a_data = 32'h333;
    bus.req_b_valid = 1'b1; bus.req_b_id = 5'd7; bus.req_b_data = 32'h444;
    tick();
    bus.req_a_data = 32'h555;
    bus.req_b_valid = 1'b0;
    #1;
    chk("t4_ra", bus.req_a_ready, 1);
    tick();
    chk("t4_we1",  bus.write_enable, 1);
    chk("t4_data", bus.reg_d_value, 32'h333);
    chk("t4_busy", bus.busy, 1);
    bus.req_a_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("t4_rst_we",   bus.write_enable, 0);
    chk("t4_rst_busy", bus.busy, 0);
    chk("t4_rst_cnt",  bus.wr_count, 0);
    chk("t4_rst_data", bus.reg_d_value, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_no_wr",  bus.write_enable, 0);
      chk("t4_cnt0",   bus.wr_count, 0);
    end

    // out-of-window id from B
    bus.req_b_valid = 1'b1; bus.req_b_id = 5'd9; bus.req_b_data = 32'h99;
    tick();
    bus.req_b_valid = 1'b0;
    tick();
`ifdef REGFILE_ARB_FILTER_EN
    chk("t5_we",   bus.write_enable, 0);
    chk("t5_drop", bus.drop_count, 1);
    chk("t5_cnt",  bus.wr_count, 0);
    chk("t5_busy", bus.busy, 0);
`else
    chk("t5_we",   bus.write_enable, 1);
    chk("t5_id",   bus.reg_id_d, 9);
    chk("t5_data", bus.reg_d_value, 32'h99);
    chk("t5_cnt",  bus.wr_count, 1);
`endif

    // counter wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_a_valid = 1'b1; bus.req_a_id = 5'd5;
    for (int i = 0; i < 65535; i++) begin
      bus.req_a_data = 32'(i);
      tick();
    end
    bus.req_a_valid = 1'b0;
    tick();
    chk("t6_cnt_max", bus.wr_count, 16'hFFFF);
    chk("t6_data_max", bus.reg_d_value, 32'd65534);
    bus.req_a_valid = 1'b1; bus.req_a_data = 32'h1234;
    tick();
    bus.req_a_valid = 1'b0;
    tick();
    chk("t6_we",   bus.write_enable, 1);
    chk("t6_data", bus.reg_d_value, 32'h1234);
    chk("t6_wrap", bus.wr_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
